// File: rtl/mat_pow_ctrl.sv
// Square-and-multiply sequencer for M^E on a packed 2x2 8-bit matrix,
// driving one external combinational matrix multiplier, one product per clock.
module mat_pow_ctrl #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_mat,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_mat,
    output logic             busy,
    output logic [31:0]      mult_a,
    output logic [31:0]      mult_b,
    input  logic [31:0]      mult_res
);

    localparam logic [31:0] IDENT = 32'h0100_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [31:0]      acc, acc_nx;
    logic [31:0]      base, base_nx;
    logic [EXP_W-1:0] e, e_nx;
    logic             mflag, mflag_nx;
    logic             sq;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= IDENT;
            base  <= '0;
            e     <= '0;
            mflag <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            base  <= base_nx;
            e     <= e_nx;
            mflag <= mflag_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        base_nx   = base;
        e_nx      = e;
        mflag_nx  = mflag;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sq        = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nx   = IDENT;
                    base_nx  = in_mat;
                    e_nx     = in_exp;
                    mflag_nx = 1'b0;
                    state_nx = (in_exp == '0) ? DONE : STEP;
                end
            end
            STEP: begin
                busy = 1'b1;
                if (e[0] && !mflag) begin
                    acc_nx = mult_res;
                    // Last set bit consumed: the trailing square would be wasted work.
                    if ((e >> 1) == '0) begin
                        state_nx = DONE;
                    end else begin
                        mflag_nx = 1'b1;
                    end
                end else begin
                    sq       = 1'b1;
                    base_nx  = mult_res;
                    e_nx     = e >> 1;
                    mflag_nx = 1'b0;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // acc*base except on square cycles; in reset this reads I and 0.
    assign mult_a  = sq ? base : acc;
    assign mult_b  = base;
    assign out_mat = acc;

endmodule

// File: tb/tb_mat_pow_ctrl.sv
// Self-checking bench for mat_pow_ctrl: table vectors, corner sequences and
// randomized jobs checked against a repeated-multiplication reference.
module tb_mat_pow_ctrl;

    localparam int EXP_W = 8;
    localparam logic [31:0] IDENT = 32'h0100_0001;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_mat;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_mat;
    logic             busy;
    logic [31:0]      mult_a;
    logic [31:0]      mult_b;
    logic [31:0]      mult_res;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    mat_pow_ctrl #(.EXP_W(EXP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_mat(out_mat),
        .busy(busy), .mult_a(mult_a), .mult_b(mult_b), .mult_res(mult_res)
    );

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] a00, a01, a10, a11, b00, b01, b10, b11;
        logic [7:0] r00, r01, r10, r11;
        a00 = a[31:24]; a01 = a[23:16]; a10 = a[15:8]; a11 = a[7:0];
        b00 = b[31:24]; b01 = b[23:16]; b10 = b[15:8]; b11 = b[7:0];
        r00 = a00 * b00 + a01 * b10;
        r01 = a00 * b01 + a01 * b11;
        r10 = a10 * b00 + a11 * b10;
        r11 = a10 * b01 + a11 * b11;
        return {r00, r01, r10, r11};
    endfunction

    always_comb mult_res = matmul(mult_a, mult_b);

    function automatic logic [31:0] pow_ref(input logic [31:0] m, input int ex);
        logic [31:0] r;
        r = IDENT;
        for (int i = 0; i < ex; i++) r = matmul(r, m);
        return r;
    endfunction

    function automatic int steps_ref(input int ex);
        int l, p;
        l = 0; p = 0;
        for (int i = 0; i < EXP_W; i++) begin
            if (ex[i]) begin
                l = i + 1;
                p++;
            end
        end
        return (ex == 0) ? 0 : (l - 1) + p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string nm, input logic [31:0] m, input logic [7:0] ex,
                           input int d, input logic [31:0] want, input int want_steps);
        int steps, guard;
        chk({nm, " in_ready before accept"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_mat = m; in_exp = ex;
        tick();
        in_valid = 1'b0; in_mat = $urandom; in_exp = 8'($urandom);
        steps = 0; guard = 0;
        while (!out_valid && guard < 600) begin
            if (busy) steps++;
            tick();
            guard++;
        end
        chk({nm, " out_valid reached"}, {31'b0, out_valid}, 32'd1);
        chk({nm, " step count"}, 32'(steps), 32'(want_steps));
        chk({nm, " out_mat"}, out_mat, want);
        for (int i = 0; i < d; i++) begin
            tick();
            chk({nm, " held out_mat"}, out_mat, want);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " idle after handshake"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] m;
        logic [7:0]  ex;
        logic [31:0] r;
        int          st;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int guard;
        logic seen;
        logic [31:0] m, rm;
        logic [7:0] ex;

        tbl[0] = '{32'h0101_0001, 8'd5,  32'h0105_0001, 4};
        tbl[1] = '{32'h0101_0100, 8'd13, 32'h79E9_E990, 6};
        tbl[2] = '{32'h1234_5678, 8'd0,  32'h0100_0001, 0};
        tbl[3] = '{32'h0200_0002, 8'd7,  32'h8000_0080, 5};
        tbl[4] = '{32'h0200_0002, 8'd8,  32'h0000_0000, 4};
        tbl[5] = '{32'h0300_0002, 8'd2,  32'h0900_0004, 2};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mat = '0; in_exp = '0;
        tick();
        tick();
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset out_mat", out_mat, IDENT);
        chk("reset mult_a", mult_a, IDENT);
        chk("reset mult_b", mult_b, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_job($sformatf("table%0d", i), tbl[i].m, tbl[i].ex, i % 3, tbl[i].r, tbl[i].st);

        // Zero exponent: DONE immediately after the accept edge.
        in_valid = 1'b1; in_mat = 32'h1234_5678; in_exp = 8'd0;
        tick();
        in_valid = 1'b0;
        chk("zero exp out_valid next cycle", {31'b0, out_valid}, 32'd1);
        chk("zero exp out_mat", out_mat, IDENT);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Backpressure with in_valid held high the whole time.
        in_valid = 1'b1; in_mat = 32'h0101_0100; in_exp = 8'd13;
        tick();
        in_mat = 32'hDEAD_BEEF; in_exp = 8'd0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            guard++;
        end
        chk("bp out_valid reached", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp held out_mat", out_mat, 32'h79E9_E990);
            chk("bp in_ready low", {30'b0, in_ready, busy}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp idle after handshake", {29'b0, in_ready, out_valid, busy}, 32'd4);
        tick();
        chk("bp held request accepted", {30'b0, out_valid, busy}, 32'd3);
        chk("bp held request result", out_mat, IDENT);
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset on the third STEP cycle of a long job.
        in_valid = 1'b1; in_mat = 32'h0101_0100; in_exp = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort job in STEP", {30'b0, out_valid, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort idle flags", {29'b0, in_ready, out_valid, busy}, 32'd4);
        chk("abort out_mat", out_mat, IDENT);
        chk("abort mult_a", mult_a, IDENT);
        chk("abort mult_b", mult_b, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("abort no out_valid", {31'b0, seen}, 32'd0);
        run_job("after abort E=1", 32'hA5C3_1E77, 8'd1, 0, 32'hA5C3_1E77, 1);

        // Randomized jobs against the reference model.
        for (int i = 0; i < 40; i++) begin
            m = $urandom;
            ex = (i < 4) ? 8'(255 - i) : 8'($urandom);
            rm = pow_ref(m, int'(ex));
            run_job($sformatf("rand%0d", i), m, ex, int'($urandom_range(0, 3)), rm, steps_ref(int'(ex)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mat_pow_ctrl.md
# mat_pow_ctrl

Sequencer that computes the matrix power M^E of a packed 2x2 8-bit matrix by driving one shared combinational 2x2 matrix multiplier (`Mat_mult`) with right-to-left square-and-multiply. It sits between a valid/ready request source and a valid/ready result sink. The multiplier is instantiated outside this block, and this block drives its operand ports. Exactly one matrix product is evaluated per clock.

## Interface
Parameters:
- EXP_W, 8, exponent width in bits

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- in_mat  in  32  base matrix {m00,m01,m10,m11}, m00 at [31:24]
- in_exp  in  EXP_W  exponent E, unsigned
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  sink accepts result
- out_mat  out  32  result matrix, same packing as in_mat
- busy  out  1  high in STEP or DONE
- mult_a  out  32  multiplier left operand
- mult_b  out  32  multiplier right operand
- mult_res  in  32  multiplier product, combinational from mult_a/mult_b

## Operation
- Registers:
  - acc, 32 bits, running result; out_mat = acc.
  - base, 32 bits, current square.
  - e, EXP_W bits, remaining exponent.
  - mflag, 1 bit, multiply for the current bit already done.
  - state.
- Arithmetic: all element arithmetic is mod 256, as produced by the multiplier. The block does no arithmetic of its own beyond the shift of e.
- Identity I = 32'h0100_0001.
- Operand mux:
  - Square cycle: mult_a = base, mult_b = base.
  - All other cycles: mult_a = acc, mult_b = base.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid: acc <= I, base <= in_mat, e <= in_exp, mflag <= 0.
    - Goes to DONE if in_exp == 0, otherwise to STEP.
  - STEP (one product per cycle):
    - Multiply cycle, when e[0]==1 and mflag==0:
      - acc <= mult_res (acc*base).
      - If (e>>1)==0, go to DONE. Otherwise mflag <= 1.
    - Square cycle, all other STEP cycles:
      - base <= mult_res (base*base).
      - e <= e>>1, mflag <= 0.
      - The square after the final multiply is never performed.
  - DONE:
    - out_valid = 1, out_mat = acc held stable.
    - On out_ready, go to IDLE.
- in_valid outside IDLE is ignored. No request is accepted in the same cycle as an output handshake.
- Reset (rst_n low at a rising edge), including mid-operation:
  - Takes effect at that edge: state IDLE, acc = I, base = 0, e = 0, mflag = 0.
  - An aborted job never produces out_valid.
- Output values while in reset and immediately after: in_ready=1, out_valid=0, busy=0, out_mat=32'h0100_0001, mult_a=32'h0100_0001, mult_b=0.

## Timing
- Accept: in_valid && in_ready sampled at edge t0.
- STEP cycle count for E>0, with L = bit length of E and P = popcount(E): (L-1)+P. The maximum is 2*EXP_W-1.
- out_valid rises in the cycle after the last STEP cycle. For E=0, out_valid is high in the cycle right after t0.
- DONE holds indefinitely under out_ready=0. out_mat, in_ready=0 and busy=1 are all stable during that time.
- The handshake completes at the first edge with out_valid && out_ready. The next cycle is IDLE with in_ready=1.
- Minimum spacing between accepted requests: (L-1)+P+2 cycles.
- mult_res is used in the cycle mult_a/mult_b are driven. The multiplier path must therefore close timing in one cycle.

## Test plan
- Reset: rst_n low for 2 cycles → in_ready=1, out_valid=0, busy=0, out_mat=32'h0100_0001, mult_b=0.
- Counting power: in_mat=32'h0101_0001, in_exp=5 → exactly 4 STEP cycles, then out_mat=32'h0105_0001.
- Fibonacci with wrap: in_mat=32'h0101_0100, in_exp=13 → 6 STEP cycles, then out_mat=32'h79E9_E990 ([[377,233],[233,144]] mod 256).
- Zero exponent: in_mat=32'h1234_5678, in_exp=0 → out_valid the cycle after accept, out_mat=32'h0100_0001, no STEP cycle.
- Backpressure: the Fibonacci job above with out_ready held low for 5 cycles in DONE, and in_valid held high throughout → out_mat stays 32'h79E9_E990, in_ready stays 0, and no new request is accepted until after the output handshake.
- Reset mid-operation: in_exp=8'hFF, with rst_n low for one edge on the 3rd STEP cycle → the next cycle is IDLE, out_valid is never asserted for that job, and a following E=1 job returns in_mat.
